// File: rtl/hex_arbiter.sv
// Two-master (CPU / debug) arbiter for an eight-digit hex display, with a post-release hold window.
// Optional ownership-limit preemption is compiled in when HEX_ARB_PREEMPT_EN is defined.
module hex_arbiter #(
  parameter int HOLD_CYCLES = 16,
  parameter int MAX_OWN     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_data,
  input  logic        dbg_req,
  input  logic [31:0] dbg_data,
  output logic        cpu_gnt,
  output logic        dbg_gnt,
  output logic [31:0] hexes,
  output logic [1:0]  owner
);

  localparam int LIMIT = (HOLD_CYCLES > MAX_OWN) ? HOLD_CYCLES : MAX_OWN;
  localparam int CW    = $clog2(LIMIT) + 1;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_OWN_CPU = 2'b01;
  localparam logic [1:0] S_OWN_DBG = 2'b10;
  localparam logic [1:0] S_HOLD    = 2'b11;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [1:0]    r_state;
  logic [CW-1:0] r_hold_cnt;
  logic          r_last_dbg;
  logic [31:0]   r_hexes;
  logic          r_cpu_gnt;
  logic          r_dbg_gnt;

  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_hold_nxt;
  logic          w_last_nxt;
  logic          w_ld_cpu;
  logic          w_ld_dbg;
  logic          w_preempt_cpu;
  logic          w_preempt_dbg;

`ifdef HEX_ARB_PREEMPT_EN
  localparam logic [CW-1:0] OWN_LAST = CW'(MAX_OWN - 1);

  logic [CW-1:0] r_own_cnt;
  logic          w_own_expired;

  // r_own_cnt is 0 in the first OWN cycle, so expiry marks the MAX_OWN-th cycle of ownership.
  assign w_own_expired = (r_own_cnt >= OWN_LAST);
  assign w_preempt_cpu = w_own_expired && dbg_req;
  assign w_preempt_dbg = w_own_expired && cpu_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_own_cnt <= '0;
    else if (w_state_nxt != r_state)
      r_own_cnt <= '0;
    else if (r_state == S_OWN_CPU || r_state == S_OWN_DBG)
      r_own_cnt <= sat_inc(r_own_cnt);
  end
`else
  assign w_preempt_cpu = 1'b0;
  assign w_preempt_dbg = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_last_nxt  = r_last_dbg;
    w_ld_cpu    = 1'b0;
    w_ld_dbg    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the CPU wins only if debug was served last.
        if (cpu_req && (!dbg_req || r_last_dbg)) begin
          w_state_nxt = S_OWN_CPU;
          w_last_nxt  = 1'b0;
        end else if (dbg_req) begin
          w_state_nxt = S_OWN_DBG;
          w_last_nxt  = 1'b1;
        end
      end
      S_OWN_CPU: begin
        if (!cpu_req || w_preempt_cpu) begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = '0;
        end else begin
          w_ld_cpu = 1'b1;
        end
      end
      S_OWN_DBG: begin
        if (!dbg_req || w_preempt_dbg) begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = '0;
        end else begin
          w_ld_dbg = 1'b1;
        end
      end
      default: begin
        if (r_hold_cnt >= HOLD_LAST) begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = sat_inc(r_hold_cnt);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_last_dbg <= 1'b1;
      r_hexes    <= 32'h0;
      r_cpu_gnt  <= 1'b0;
      r_dbg_gnt  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_last_dbg <= w_last_nxt;
      r_cpu_gnt  <= (w_state_nxt == S_OWN_CPU);
      r_dbg_gnt  <= (w_state_nxt == S_OWN_DBG);
      if (w_ld_cpu)
        r_hexes <= cpu_data;
      else if (w_ld_dbg)
        r_hexes <= dbg_data;
    end
  end

  assign cpu_gnt = r_cpu_gnt;
  assign dbg_gnt = r_dbg_gnt;
  assign hexes   = r_hexes;
  assign owner   = r_state;

endmodule

// File: doc/hex_arbiter.md
HEX_ARBITER -- requirements
Module: hex_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 16, which sets the minimum number of display-hold cycles after an owner releases.
REQ-002 The block SHALL have parameter MAX_OWN, default 64, which sets the ownership limit in cycles (used only when the macro of REQ-021 is defined).
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port cpu_req, input, width 1: CPU requests the display.
REQ-006 The block SHALL have port cpu_data, input, width 32: CPU display value, 8 nibbles, nibble 0 = rightmost digit.
REQ-007 The block SHALL have port dbg_req, input, width 1: debug monitor requests the display.
REQ-008 The block SHALL have port dbg_data, input, width 32: debug display value.
REQ-009 The block SHALL have port cpu_gnt, output, width 1: CPU owns the display.
REQ-010 The block SHALL have port dbg_gnt, output, width 1: debug owns the display.
REQ-011 The block SHALL have port hexes, output, width 32: registered value driven to the eight 7-segment decoders.
REQ-012 The block SHALL have port owner, output, width 2: 00 IDLE, 01 OWN_CPU, 10 OWN_DBG, 11 HOLD.

Function
REQ-013 The FSM SHALL have states IDLE, OWN_CPU, OWN_DBG and HOLD; owner SHALL equal the current state encoding.
REQ-014 In IDLE, a single requester SHALL move the FSM to its OWN state on the next edge; cpu_gnt or dbg_gnt SHALL be registered and asserted from that cycle.
REQ-015 In IDLE with both requests high, the requester not served last SHALL win (round-robin); the last-served bit SHALL update on every entry to an OWN state.
REQ-016 While in OWN_x with x_req high, hexes SHALL load x_data on each edge, giving one-cycle latency from data to display; the other requester's data SHALL never reach hexes.
REQ-017 In OWN_x, x_req low at an edge SHALL move the FSM to HOLD, deassert the grant and leave hexes unchanged.
REQ-018 HOLD SHALL last exactly HOLD_CYCLES cycles, counted by a counter loaded with 0 on entry, then go to IDLE; requests during HOLD SHALL be ignored and stay pending, and hexes SHALL be frozen.
REQ-019 Both grants SHALL never be high together, and each grant SHALL be high only in its OWN state.
REQ-020 The counter width SHALL be $clog2 of max(HOLD_CYCLES, MAX_OWN) plus 1, and the counter SHALL saturate rather than wrap.

Configuration
REQ-021 With macro HEX_ARB_PREEMPT_EN defined, the block SHALL count OWN_x cycles; when the count reaches MAX_OWN while the other requester is high, it SHALL force HOLD as if x_req had dropped.
REQ-022 With HEX_ARB_PREEMPT_EN undefined, ownership SHALL be unlimited, MAX_OWN SHALL be ignored, and no ownership counter logic SHALL exist.

Reset
REQ-023 Asserting rst low SHALL immediately, without waiting for clk, set the state to IDLE, hexes to 32'h0, cpu_gnt and dbg_gnt to 0, owner to 00, and counters to 0.
REQ-024 Reset SHALL set the last-served bit to debug, so the CPU wins the first tie.
REQ-025 Reset asserted mid-OWN or mid-HOLD SHALL abort the operation; after rst rises, arbitration SHALL restart from IDLE on the next edge.

Verification
REQ-026 Reset release, cpu_req=1, cpu_data=32'h12345678 -> cpu_gnt=1 at edge 1, hexes=32'h12345678 at edge 2, owner=01.
REQ-027 cpu_req and dbg_req rise together from reset -> CPU is granted; after CPU release plus 16 HOLD cycles, dbg_gnt=1 while cpu_req is still pending.
REQ-028 CPU drops req after writing 32'hDEADBEEF, then dbg_req=1 immediately -> hexes holds 32'hDEADBEEF, owner=11 for exactly 16 cycles, then dbg_gnt=1.
REQ-029 With HEX_ARB_PREEMPT_EN, MAX_OWN=4, CPU holds req and dbg_req=1 -> HOLD is entered after 4 CPU cycles, then dbg_gnt=1; without the macro, CPU keeps the grant for 1000 cycles.
REQ-030 rst pulsed low mid-HOLD, asynchronous to clk -> hexes=0, owner=00 and both grants=0 within the same cycle.
REQ-031 A checker SHALL fire if cpu_gnt and dbg_gnt are ever both high, and SHALL remain silent across a random 10k-cycle request test.
